// File: rtl/apb_arbiter_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_arbiter_master: two-requester round-robin arbiter driving one APB     |
// | master port, with an ACCESS-phase timeout. Revision: 1.0                  |
// +--------------------------------------------------------------------------+
module apb_arbiter_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          grant,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                win;

  // Preferred requester wins if asking, otherwise the other one does.
  assign win = req[rr_q] ? rr_q : ~rr_q;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    grant_d   = grant_q;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (req != 2'b00) begin
          pwrite_d  = win ? req_write[1] : req_write[0];
          paddr_d   = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          pwdata_d  = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          grant_d   = win ? 2'b10 : 2'b01;
          rr_d      = ~win;
          psel_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = 8'd0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done_d    = grant_q;
          rdata_d   = pwrite_q ? '0 : prdata;
          err_d     = pslverr;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          grant_d   = 2'b00;
          state_d   = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          done_d    = grant_q;
          rdata_d   = '0;
          err_d     = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          grant_d   = 2'b00;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      grant_q   <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_arbiter_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apb_arbiter_master: directed bench with a small APB slave model.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_apb_arbiter_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                pclk = 1'b0;
  logic                rst;
  logic [1:0]          req;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          grant;
  logic [1:0]          done;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  int n_checks = 0;
  int n_errors = 0;

  // 0: zero-wait slave, 1: one registered wait state, 2: never ready
  int                  mode;
  logic                pready_q;
  logic [DATA_W-1:0]   mem [0:255];

  always #5 pclk = ~pclk;

  apb_arbiter_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .pclk(pclk), .rst(rst), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always_comb begin
    pready = (mode == 0) ? 1'b1 : (mode == 1) ? pready_q : 1'b0;
    prdata = mem[paddr[7:0]];
  end

  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) mem[paddr[7:0]] <= pwdata;
    pready_q <= (mode == 1) && psel && penable && !pready_q;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  logic [1:0] exp_grant [0:6] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
  logic [1:0] exp_done  [0:6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};

  initial begin
    int pen_cycles;
    bit seen;
    rst = 1'b1; req = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    pslverr = 1'b0; mode = 0;
    tick(); tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_paddr", paddr, 0);
    rst = 1'b0;

    // Zero-wait write from requester 0
    req = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h4; req_wdata[31:0] = 32'hDEADBEEF;
    tick();
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_grant", grant, 2'b01);
    check("wr_setup_pwrite", pwrite, 1);
    req_addr[31:0] = 32'h99; req_wdata[31:0] = 32'h0;
    tick();
    check("wr_access_penable", penable, 1);
    check("wr_access_paddr", paddr, 32'h4);
    check("wr_access_pwdata", pwdata, 32'hDEADBEEF);
    tick();
    check("wr_done", done, 2'b01);
    check("wr_err", resp_err, 0);
    check("wr_psel_drop", psel, 0);
    check("wr_grant_drop", grant, 0);
    req = 2'b00;
    tick();
    check("wr_mem", mem[4], 32'hDEADBEEF);
    check("wr_done_pulse", done, 0);

    // Zero-wait read from requester 1
    req = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h4;
    tick();
    check("rd_setup_grant", grant, 2'b10);
    check("rd_setup_paddr", paddr, 32'h4);
    tick();
    check("rd_access_paddr", paddr, 32'h4);
    check("rd_access_penable", penable, 1);
    tick();
    check("rd_done", done, 2'b10);
    check("rd_rdata", resp_rdata, 32'hDEADBEEF);
    req = 2'b00;
    tick();
    check("rd_rdata_hold", resp_rdata, 32'hDEADBEEF);

    // Round-robin with both requesting, from reset
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11; req_write = 2'b00; req_addr = {32'h4, 32'h4};
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("rr_grant_%0d", i), grant, exp_grant[i]);
      check($sformatf("rr_done_%0d", i), done, exp_done[i]);
    end
    req = 2'b00;
    rst = 1'b1; tick(); rst = 1'b0;

    // One registered wait state
    mode = 1; req = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h4;
    tick();
    check("ws_setup_penable", penable, 0);
    tick();
    check("ws_access1_penable", penable, 1);
    check("ws_access1_done", done, 0);
    tick();
    check("ws_access2_penable", penable, 1);
    check("ws_access2_done", done, 0);
    tick();
    check("ws_done", done, 2'b01);
    check("ws_rdata", resp_rdata, 32'hDEADBEEF);
    req = 2'b00;
    tick();

    // Timeout against a slave that never answers
    mode = 2; req = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h8;
    req_wdata[63:32] = 32'h1234;
    pen_cycles = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done != 2'b00) seen = 1;
      else if (penable) pen_cycles++;
    end
    check("to_seen", seen, 1);
    check("to_penable_cycles", pen_cycles, 16);
    check("to_done", done, 2'b10);
    check("to_err", resp_err, 1);
    check("to_rdata", resp_rdata, 0);
    check("to_psel", psel, 0);
    req = 2'b00;
    tick();

    // Slave error on a zero-wait read
    mode = 0; pslverr = 1'b1; req = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h4;
    tick(); tick(); tick();
    check("se_done", done, 2'b01);
    check("se_err", resp_err, 1);
    check("se_rdata", resp_rdata, 32'hDEADBEEF);
    req = 2'b00; pslverr = 1'b0;
    tick();

    // Reset in the middle of ACCESS abandons the transfer
    mode = 2; req = 2'b01;
    tick(); tick();
    check("ra_in_access", penable, 1);
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0;
    check("ra_psel", psel, 0);
    check("ra_penable", penable, 0);
    check("ra_grant", grant, 0);
    check("ra_done", done, 0);
    tick();
    check("ra_done_after", done, 0);
    mode = 0; req = 2'b10; req_write = 2'b00;
    tick();
    check("ra_next_grant", grant, 2'b10);
    tick(); tick();
    check("ra_next_done", done, 2'b10);
    req = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
